free_list: RTL and testbench

Circular pool of unallocated physical register IDs for the rename stage. It presents the next SS free physical registers to rename/dispatch every cycle, in show-ahead order. It removes them in one all-or-nothing pop when dispatch consumes a bundle. It takes back up to SS freed physical registers per cycle from ROB commit.

---
 rtl/free_list_if.sv | 27 ++
 rtl/free_list.sv | 94 +++++++++
 tb/tb_free_list.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/free_list_if.sv
// Handshake bundle between the free list and its rename/dispatch and commit clients.
//   master : dispatch/commit side; drives pop_free_list, push_valid and push_regs.
//   slave  : free list side; drives free_list_regs, free_list_empty, free_count
//            and overflow_err.
interface free_list_if #(
  parameter int unsigned SS         = 2,
  parameter int unsigned PR_ENTRIES = 64,
  parameter int unsigned PW         = $clog2(PR_ENTRIES)
);
  logic                  pop_free_list;
  logic [SS-1:0][PW-1:0] free_list_regs;
  logic                  free_list_empty;
  logic [SS-1:0]         push_valid;
  logic [SS-1:0][PW-1:0] push_regs;
  logic [PW:0]           free_count;
  logic                  overflow_err;

  modport master (
    output pop_free_list, push_valid, push_regs,
    input  free_list_regs, free_list_empty, free_count, overflow_err
  );

  modport slave (
    input  pop_free_list, push_valid, push_regs,
    output free_list_regs, free_list_empty, free_count, overflow_err
  );
endinterface

// File: rtl/free_list.sv
// Circular pool of unallocated physical register IDs for the rename stage.
// Shows the next SS free registers in head order, removes them in one
// all-or-nothing pop, and accepts up to SS freed registers per cycle.
//   clk : clock
//   rst : asynchronous, active-high reset
//   fl  : free_list_if slave port (pop, push lanes, head regs, count, status)
module free_list #(
  parameter int unsigned SS         = 2,
  parameter int unsigned PR_ENTRIES = 64,
  parameter int unsigned PW         = $clog2(PR_ENTRIES)
) (
  input logic        clk,
  input logic        rst,
  free_list_if.slave fl
);

  localparam logic [PW+1:0] Cap    = (PW+2)'(PR_ENTRIES);
  localparam logic [PW:0]   SsCnt  = (PW+1)'(SS);
  localparam logic [PW:0]   InitCt = (PW+1)'(PR_ENTRIES - 32);

  logic [PW-1:0] entry_q [PR_ENTRIES];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;

  logic                  pop_ok;
  logic [PW:0]           avail;
  logic [PW:0]           n_fit;
  logic                  drop;
  logic [SS-1:0]         wr_en;
  logic [SS-1:0][PW-1:0] wr_idx;
  logic [SS-1:0][PW-1:0] wr_data;

  always_comb begin
    pop_ok  = fl.pop_free_list && (count_q >= SsCnt);
    avail   = pop_ok ? (count_q - SsCnt) : count_q;
    n_fit   = '0;
    drop    = 1'b0;
    wr_en   = '0;
    wr_idx  = '0;
    wr_data = '0;
    // Compact valid, non-p0 lanes in lane order; once the list is full every
    // later kept lane is dropped too, since n_fit stops advancing.
    for (int unsigned i = 0; i < SS; i++) begin
      if (fl.push_valid[i] && (fl.push_regs[i] != '0)) begin
        if (({1'b0, avail} + {1'b0, n_fit}) < Cap) begin
          wr_en[i]   = 1'b1;
          wr_idx[i]  = tail_q + n_fit[PW-1:0];
          wr_data[i] = fl.push_regs[i];
          n_fit      = n_fit + 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
    end
    head_d     = pop_ok ? (head_q + PW'(SS)) : head_q;
    tail_d     = tail_q + n_fit[PW-1:0];
    count_d    = avail + n_fit;
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Upper 32 slots get wrapped values; they lie beyond count and are unused.
      for (int unsigned i = 0; i < PR_ENTRIES; i++) begin
        entry_q[i] <= PW'(i + 32);
      end
      head_q     <= '0;
      tail_q     <= PW'(PR_ENTRIES - 32);
      count_q    <= InitCt;
      overflow_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < SS; i++) begin
        if (wr_en[i]) entry_q[wr_idx[i]] <= wr_data[i];
      end
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    fl.free_list_regs = '0;
    for (int unsigned i = 0; i < SS; i++) begin
      fl.free_list_regs[i] = entry_q[head_q + PW'(i)];
    end
    fl.free_list_empty = (count_q < SsCnt);
    fl.free_count      = count_q;
    fl.overflow_err    = overflow_q;
  end

endmodule

// File: tb/tb_free_list.sv
module tb_free_list;

  localparam int unsigned SS = 2;
  localparam int unsigned PR = 64;
  localparam int unsigned PW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;

  free_list_if #(.SS(SS), .PR_ENTRIES(PR), .PW(PW)) fl_if ();

  free_list #(.SS(SS), .PR_ENTRIES(PR), .PW(PW)) dut (
    .clk (clk),
    .rst (rst),
    .fl  (fl_if.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    fl_if.pop_free_list = 1'b0;
    fl_if.push_valid    = '0;
    fl_if.push_regs     = '0;
  endtask

  // Advance one edge; inputs and samples sit 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic check_head(input string tag, input int r0, input int r1);
    check({tag, "_r0"}, 32'(fl_if.free_list_regs[0]), r0);
    check({tag, "_r1"}, 32'(fl_if.free_list_regs[1]), r1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    step();
    do_reset();

    // Reset state
    check_head("rst", 32, 33);
    check("rst_count", 32'(fl_if.free_count), 32);
    check("rst_empty", 32'(fl_if.free_list_empty), 0);
    check("rst_ovf", 32'(fl_if.overflow_err), 0);

    // Drain with 16 pops
    for (int k = 0; k < 16; k++) begin
      fl_if.pop_free_list = 1'b1;
      step();
      if (k < 15) check_head("pop", 34 + 2 * k, 35 + 2 * k);
      check("pop_count", 32'(fl_if.free_count), 32'(30 - 2 * k));
    end
    check("drain_empty", 32'(fl_if.free_list_empty), 1);
    step();  // 17th pop, ignored
    check("pop17_count", 32'(fl_if.free_count), 0);
    check("pop17_empty", 32'(fl_if.free_list_empty), 1);
    check("pop17_ovf", 32'(fl_if.overflow_err), 0);

    // Push at count 0; head == tail only if the ignored pop moved nothing
    idle();
    fl_if.push_valid   = 2'b11;
    fl_if.push_regs[0] = 6'd5;
    fl_if.push_regs[1] = 6'd7;
    step();
    check_head("push57", 5, 7);
    check("push57_count", 32'(fl_if.free_count), 2);
    check("push57_empty", 32'(fl_if.free_list_empty), 0);

    fl_if.pop_free_list = 1'b1;
    fl_if.push_regs[0]  = 6'd9;
    fl_if.push_regs[1]  = 6'd11;
    step();
    check_head("poppush", 9, 11);
    check("poppush_count", 32'(fl_if.free_count), 2);

    // Compaction: only lane 1 valid; lane 0 carries garbage
    idle();
    fl_if.push_valid   = 2'b10;
    fl_if.push_regs[0] = 6'd63;
    fl_if.push_regs[1] = 6'd9;
    step();
    check("cmp1_count", 32'(fl_if.free_count), 3);
    // p0 on lane 0 is skipped, 12 lands right after 9
    fl_if.push_valid   = 2'b11;
    fl_if.push_regs[0] = 6'd0;
    fl_if.push_regs[1] = 6'd12;
    step();
    check("cmp2_count", 32'(fl_if.free_count), 4);
    idle();
    fl_if.pop_free_list = 1'b1;
    step();
    check_head("cmp", 9, 12);
    check("cmp_count", 32'(fl_if.free_count), 2);
    step();
    check("cmp_drain", 32'(fl_if.free_count), 0);

    // Wrap-around with a FIFO model
    do_reset();
    q.delete();
    for (int i = 32; i < 64; i++) q.push_back(i);
    fl_if.push_valid   = 2'b11;
    fl_if.push_regs[0] = 6'd1;
    fl_if.push_regs[1] = 6'd2;
    q.push_back(1);
    q.push_back(2);
    step();
    check("wrap_init_count", 32'(fl_if.free_count), 34);
    for (int k = 0; k < 20; k++) begin
      int a, b;
      a = 3 + 2 * k;
      b = 4 + 2 * k;
      fl_if.pop_free_list = 1'b1;
      fl_if.push_regs[0]  = PW'(a);
      fl_if.push_regs[1]  = PW'(b);
      void'(q.pop_front());
      void'(q.pop_front());
      q.push_back(a);
      q.push_back(b);
      step();
      check_head("wrap", q[0], q[1]);
      check("wrap_count", 32'(fl_if.free_count), 32'(q.size()));
    end
    idle();
    fl_if.pop_free_list = 1'b1;
    while (q.size() >= 2) begin
      check_head("wrap_drain", q[0], q[1]);
      void'(q.pop_front());
      void'(q.pop_front());
      step();
      check("wrap_drain_count", 32'(fl_if.free_count), 32'(q.size()));
    end
    check("wrap_empty", 32'(fl_if.free_list_empty), 1);

    // Overflow
    do_reset();
    fl_if.push_valid = 2'b11;
    for (int k = 0; k < 16; k++) begin
      fl_if.push_regs[0] = PW'(2 * k + 1);
      fl_if.push_regs[1] = PW'(2 * k + 2);
      step();
    end
    check("full_count", 32'(fl_if.free_count), 64);
    check("full_ovf", 32'(fl_if.overflow_err), 0);
    fl_if.push_valid   = 2'b01;
    fl_if.push_regs[0] = 6'd40;
    step();
    idle();
    check("ovf_count", 32'(fl_if.free_count), 64);
    check("ovf_flag", 32'(fl_if.overflow_err), 1);
    check_head("ovf_head", 32, 33);
    step();
    check("ovf_sticky", 32'(fl_if.overflow_err), 1);

    // Async reset between edges
    fl_if.pop_free_list = 1'b1;
    step();
    check_head("pre_arst", 34, 35);
    idle();
    #2;
    rst = 1'b1;
    #1;
    check_head("arst", 32, 33);
    check("arst_count", 32'(fl_if.free_count), 32);
    check("arst_ovf", 32'(fl_if.overflow_err), 0);
    check("arst_empty", 32'(fl_if.free_list_empty), 0);
    #1;
    rst = 1'b0;
    fl_if.pop_free_list = 1'b1;
    step();
    idle();
    check_head("post_arst", 34, 35);
    check("post_arst_count", 32'(fl_if.free_count), 30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
